ad5674_spi_drv: RTL and testbench
=================================

Name: ad5674_spi_drv

Overview:
- Downstream consumer of the per-channel DAC update stream: trigger pulse, 5-bit channel, 12-bit code.
- Packs each update into a 24-bit AD5674 write-and-update frame.
- Shifts the frame out over SPI to one of two daisy-free AD5674 devices (32 channels total). Channel bit 4 selects the device's SYNC.
- Holds a one-deep pending buffer so a trigger arriving mid-frame is not lost.

Parameters:
- CLK_DIV, 4, SCLK half-period in clk cycles; legal range 2..255.
- GAP_CYC, 8, SYNC_n high time between frames in clk cycles; legal range 1..255.
- CMD, 4'h3, AD5674 command nibble (write to and update DAC n).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ad5674_trig  in  1  single-cycle update request
- ad5674_ch  in  5  channel; [4] = device select, [3:0] = DAC address
- ad5674_din  in  12  DAC code
- ad5674_sclk  out  1  SPI clock; idles high
- ad5674_sync_n  out  2  per-device frame select, active low
- ad5674_sdi  out  1  serial data, MSB first
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at the end of each frame
- drop_cnt  out  8  saturating count of overwritten pending requests

Behaviour:
- Reset values:
  - sclk = 1, sync_n = 2'b11, sdi = 0, busy = 0, done = 0, drop_cnt = 0.
  - Pending buffer is empty; state = IDLE.
  - Reset is asynchronous and may occur mid-frame. It aborts immediately to these values with no partial completion and no done pulse.
- Frame word, captured at acceptance: {CMD, ch[3:0], din[11:0], 4'b0000}. Device index dev = ch[4].
- Acceptance:
  - In IDLE, trig high at cycle T0 → capture frame/dev → SETUP at T0+1.
  - trig while busy: stores {ch, din} in the pending buffer and sets pending_vld.
  - trig while pending_vld = 1 already: overwrites the buffer and increments drop_cnt, saturating at 255.
- SETUP (CLK_DIV cycles):
  - sync_n[dev] = 0, other bit stays 1.
  - sclk = 1; sdi = frame[23].
- SHIFT: for each bit k = 23..0:
  - Low phase: CLK_DIV cycles, sclk = 0. The device samples sdi at the falling edge entering this phase.
  - High phase: CLK_DIV cycles, sclk = 1. sdi updates to frame[k-1] at the rising edge.
  - For the high phase after bit 0, sdi = 0; this phase is the SYNC hold time.
  - A bit counter (5 bits) and a phase counter (8 bits) drive the sequence; exactly 24 falling edges per frame.
- Frame timing with CLK_DIV = 4, T0 = cycle trig is sampled:
  - SYNC low for 49*CLK_DIV cycles: sync_n[dev] = 0 from T0+1 through T0+196, and returns high at T0+197.
- GAP (GAP_CYC cycles):
  - sync_n = 2'b11, sclk = 1, sdi = 0.
  - done = 1 on the last GAP cycle (T0+204 with the defaults).
- End of GAP:
  - If pending_vld, load the pending entry as a new frame and clear pending_vld; SETUP follows next cycle and busy stays high.
  - Otherwise go to IDLE; busy = 0 from T0+205.
- Simultaneous events:
  - trig on the last GAP cycle with pending empty: stored as pending, then launched immediately.
  - trig on the last GAP cycle with pending full: overwrites pending before launch; drop_cnt increments.
- Inputs ch/din are sampled only on a trig cycle; changes at other times have no effect on a frame in flight.
- All outputs are registered.

Test Plan:
- Single update (CLK_DIV = 4, GAP_CYC = 8): trig with ch = 5'd3, din = 12'hABC → SPI monitor decodes 24'h33ABC0 on sync_n[0]; sync_n[1] stays 1; sync low exactly 196 cycles; 24 falling edges; done at T0+204; busy low at T0+205.
- Device select: ch = 5'd18, din = 12'h001 → frame 24'h320010 on sync_n[1] only; sync_n[0] held high throughout.
- Back-to-back:
  - trig (ch 0, 12'h111) at T0, then trig (ch 1, 12'h222) at T0+50 → second frame 24'h312220 starts SETUP at T0+205 with no idle cycle; drop_cnt = 0.
  - Add a third trig at T0+60 (ch 2, 12'h333) → second frame carries 24'h323330; drop_cnt = 1.
- Saturation: 300 overwriting trigs during one frame → drop_cnt stops at 255.
- Reset mid-frame: assert rst at T0+100 → same cycle sync_n = 2'b11, sclk = 1, sdi = 0, busy = 0, no done pulse. A trig after deassert → clean full frame.
- Boundary divider CLK_DIV = 2 with ch = 5'd31, din = 12'hFFF → frame 24'h3FFFF0 on sync_n[1]; sync low 98 cycles.

Source files
------------

// File: rtl/ad5674_spi_drv.sv
// ad5674_spi_drv
// Turns the per-channel DAC update stream (trigger, 5-bit channel, 12-bit code)
// into 24-bit AD5674 write-and-update frames and shifts them out over SPI to
// one of two AD5674 devices. Channel bit 4 selects which device's SYNC is
// driven. A one-deep pending buffer catches a trigger that arrives mid-frame.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   ad5674_trig    single-cycle update request
//   ad5674_ch      [4] device select, [3:0] DAC address
//   ad5674_din     12-bit DAC code
//   ad5674_sclk    SPI clock, idles high
//   ad5674_sync_n  per-device frame select, active low
//   ad5674_sdi     serial data, MSB first
//   busy           high whenever a frame (or its gap) is in progress
//   done           one-cycle pulse on the last gap cycle of each frame
//   drop_cnt       saturating count of overwritten pending requests
module ad5674_spi_drv #(
  parameter int         CLK_DIV = 4,
  parameter int         GAP_CYC = 8,
  parameter logic [3:0] CMD     = 4'h3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ad5674_trig,
  input  logic [4:0]  ad5674_ch,
  input  logic [11:0] ad5674_din,
  output logic        ad5674_sclk,
  output logic [1:0]  ad5674_sync_n,
  output logic        ad5674_sdi,
  output logic        busy,
  output logic        done,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  state_t      state, state_next;
  logic [7:0]  phase, phase_next;
  logic [4:0]  bit_cnt, bit_next;
  logic        hi_ph, hi_next;          // 0 = SCLK low phase, 1 = high phase
  logic [23:0] frame, frame_next;
  logic        dev, dev_next;
  logic [4:0]  pend_ch, pend_ch_next;
  logic [11:0] pend_din, pend_din_next;
  logic        pend_vld, pend_vld_next;
  logic [7:0]  drop_next;
  logic        launch;
  logic [4:0]  launch_ch;
  logic [11:0] launch_din;
  logic        sclk_next, sdi_next, busy_next, done_next;
  logic [1:0]  sync_n_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      phase         <= 8'd0;
      bit_cnt       <= 5'd0;
      hi_ph         <= 1'b0;
      frame         <= 24'd0;
      dev           <= 1'b0;
      pend_ch       <= 5'd0;
      pend_din      <= 12'd0;
      pend_vld      <= 1'b0;
      drop_cnt      <= 8'd0;
      ad5674_sclk   <= 1'b1;
      ad5674_sync_n <= 2'b11;
      ad5674_sdi    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_next;
      phase         <= phase_next;
      bit_cnt       <= bit_next;
      hi_ph         <= hi_next;
      frame         <= frame_next;
      dev           <= dev_next;
      pend_ch       <= pend_ch_next;
      pend_din      <= pend_din_next;
      pend_vld      <= pend_vld_next;
      drop_cnt      <= drop_next;
      ad5674_sclk   <= sclk_next;
      ad5674_sync_n <= sync_n_next;
      ad5674_sdi    <= sdi_next;
      busy          <= busy_next;
      done          <= done_next;
    end
  end

  always_comb begin
    state_next    = state;
    phase_next    = phase;
    bit_next      = bit_cnt;
    hi_next       = hi_ph;
    frame_next    = frame;
    dev_next      = dev;
    pend_ch_next  = pend_ch;
    pend_din_next = pend_din;
    pend_vld_next = pend_vld;
    drop_next     = drop_cnt;
    launch        = 1'b0;
    launch_ch     = ad5674_ch;
    launch_din    = ad5674_din;

    // Any trigger while busy lands in the pending buffer first; on the last
    // gap cycle the launch below then picks it straight back up.
    if (ad5674_trig && state != IDLE) begin
      pend_ch_next  = ad5674_ch;
      pend_din_next = ad5674_din;
      pend_vld_next = 1'b1;
      if (pend_vld && drop_cnt != 8'hFF)
        drop_next = drop_cnt + 8'd1;
    end

    case (state)
      IDLE: begin
        if (ad5674_trig)
          launch = 1'b1;
      end
      SETUP: begin
        if (phase == DIV_LAST) begin
          state_next = SHIFT;
          phase_next = 8'd0;
          hi_next    = 1'b0;
          bit_next   = 5'd23;
        end else begin
          phase_next = phase + 8'd1;
        end
      end
      SHIFT: begin
        if (phase != DIV_LAST) begin
          phase_next = phase + 8'd1;
        end else begin
          phase_next = 8'd0;
          if (!hi_ph) begin
            hi_next = 1'b1;
          end else if (bit_cnt == 5'd0) begin
            state_next = GAP;        // high phase after bit 0 was the SYNC hold
          end else begin
            bit_next = bit_cnt - 5'd1;
            hi_next  = 1'b0;
          end
        end
      end
      GAP: begin
        if (phase != GAP_LAST) begin
          phase_next = phase + 8'd1;
        end else if (pend_vld_next) begin
          launch        = 1'b1;
          launch_ch     = pend_ch_next;
          launch_din    = pend_din_next;
          pend_vld_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (launch) begin
      frame_next = {CMD, launch_ch[3:0], launch_din, 4'b0000};
      dev_next   = launch_ch[4];
      state_next = SETUP;
      phase_next = 8'd0;
    end

    // Outputs are computed from the next state so they leave the flops
    // aligned with the state they belong to.
    sclk_next   = !(state_next == SHIFT && !hi_next);
    sync_n_next = 2'b11;
    if (state_next == SETUP || state_next == SHIFT)
      sync_n_next[dev_next] = 1'b0;
    sdi_next = 1'b0;
    if (state_next == SETUP)
      sdi_next = frame_next[23];
    else if (state_next == SHIFT) begin
      if (!hi_next)
        sdi_next = frame_next[bit_next];
      else if (bit_next != 5'd0)
        sdi_next = frame_next[bit_next - 5'd1];
    end
    busy_next = (state_next != IDLE);
    done_next = (state_next == GAP) && (phase_next == GAP_LAST);
  end

endmodule

// File: tb/tb_ad5674_spi_drv.sv
module tb_ad5674_spi_drv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig = 1'b0;
  logic [4:0]  ch = 5'd0;
  logic [11:0] din = 12'd0;
  logic        sel = 1'b0;   // 0 = default instance, 1 = CLK_DIV=2 instance

  logic        sclk1, sdi1, busy1, done1;
  logic [1:0]  sync1;
  logic [7:0]  drop1;
  logic        sclk2, sdi2, busy2, done2;
  logic [1:0]  sync2;
  logic [7:0]  drop2;

  wire trig1 = trig & ~sel;
  wire trig2 = trig & sel;

  wire       m_sclk = sel ? sclk2 : sclk1;
  wire       m_sdi  = sel ? sdi2  : sdi1;
  wire       m_busy = sel ? busy2 : busy1;
  wire       m_done = sel ? done2 : done1;
  wire [1:0] m_sync = sel ? sync2 : sync1;
  wire [7:0] m_drop = sel ? drop2 : drop1;

  ad5674_spi_drv #(.CLK_DIV(4), .GAP_CYC(8), .CMD(4'h3)) dut (
    .clk(clk), .rst(rst), .ad5674_trig(trig1), .ad5674_ch(ch), .ad5674_din(din),
    .ad5674_sclk(sclk1), .ad5674_sync_n(sync1), .ad5674_sdi(sdi1),
    .busy(busy1), .done(done1), .drop_cnt(drop1));

  ad5674_spi_drv #(.CLK_DIV(2), .GAP_CYC(8), .CMD(4'h3)) dut2 (
    .clk(clk), .rst(rst), .ad5674_trig(trig2), .ad5674_ch(ch), .ad5674_din(din),
    .ad5674_sclk(sclk2), .ad5674_sync_n(sync2), .ad5674_sdi(sdi2),
    .busy(busy2), .done(done2), .drop_cnt(drop2));

  always #5 clk = ~clk;

  int ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  // SPI monitor: decodes frames from the selected instance.
  logic [1:0]  p_sync = 2'b11, start_pat = 2'b11;
  logic        p_sclk = 1'b1, p_busy = 1'b0, in_frame = 1'b0, glitch = 1'b0;
  logic [23:0] shreg = 24'd0, f_word = 24'd0;
  int          low_cnt = 0, falls = 0, cur_start = 0;
  int          f_low = 0, f_falls = 0, f_start = 0, frame_cnt = 0;
  logic        f_dev = 1'b0, f_glitch = 1'b0;
  int          done_cnt = 0, last_done = 0, last_idle = 0;

  always @(negedge clk) begin
    if (rst) begin
      p_sync   <= 2'b11;
      p_sclk   <= 1'b1;
      p_busy   <= 1'b0;
      in_frame <= 1'b0;
    end else begin
      p_sync <= m_sync;
      p_sclk <= m_sclk;
      p_busy <= m_busy;
      if (m_done) begin
        done_cnt  <= done_cnt + 1;
        last_done <= ncyc;
      end
      if (p_busy && !m_busy) last_idle <= ncyc;
      if (p_sync == 2'b11 && m_sync != 2'b11) begin
        start_pat <= m_sync;
        cur_start <= ncyc;
        low_cnt   <= 1;
        falls     <= 0;
        shreg     <= 24'd0;
        glitch    <= (m_sync == 2'b00);
        in_frame  <= 1'b1;
      end else if (in_frame && m_sync != 2'b11) begin
        low_cnt <= low_cnt + 1;
        if (m_sync != start_pat) glitch <= 1'b1;
        if (p_sclk && !m_sclk) begin
          falls <= falls + 1;
          shreg <= {shreg[22:0], m_sdi};
        end
      end else if (in_frame && m_sync == 2'b11) begin
        in_frame  <= 1'b0;
        frame_cnt <= frame_cnt + 1;
        f_word    <= shreg;
        f_falls   <= falls;
        f_low     <= low_cnt;
        f_dev     <= (start_pat == 2'b01);
        f_glitch  <= glitch;
        f_start   <= cur_start;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise trig for one cycle at (or after) cycle 'at'; t0 is the trig cycle.
  task automatic pulse(input logic [4:0] c, input logic [11:0] d, input int at, output int t0);
    @(negedge clk);
    while (ncyc < at) @(negedge clk);
    trig = 1'b1;
    ch   = c;
    din  = d;
    t0   = ncyc;
    @(negedge clk);
    trig = 1'b0;
    ch   = 5'd0;
    din  = 12'd0;
    #1;
  endtask

  task automatic wait_frame(input int limit);
    int start;
    start = frame_cnt;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if (frame_cnt != start) break;
    end
    check("frame_arrived", frame_cnt - start, 1);
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if (!m_busy) break;
    end
    check("idle_reached", {31'd0, m_busy}, 0);
  endtask

  initial begin
    int t0, t1, t2, dc, fc;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_sclk", {31'd0, m_sclk}, 1);
    check("rst_sync", {30'd0, m_sync}, 2'b11);
    check("rst_sdi", {31'd0, m_sdi}, 0);
    check("rst_busy", {31'd0, m_busy}, 0);
    check("rst_done", {31'd0, m_done}, 0);
    check("rst_drop", {24'd0, m_drop}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single update to device 0
    dc = done_cnt;
    pulse(5'd3, 12'hABC, 0, t0);
    check("t1_busy", {31'd0, m_busy}, 1);
    check("t1_sync_setup", {30'd0, m_sync}, 2'b10);
    check("t1_sclk_setup", {31'd0, m_sclk}, 1);
    wait_frame(400);
    check("t1_word", {8'd0, f_word}, 32'h33ABC0);
    check("t1_dev", {31'd0, f_dev}, 0);
    check("t1_glitch", {31'd0, f_glitch}, 0);
    check("t1_falls", f_falls, 24);
    check("t1_low", f_low, 196);
    check("t1_start", f_start, t0 + 1);
    wait_idle(100);
    check("t1_done_at", last_done, t0 + 204);
    check("t1_idle_at", last_idle, t0 + 205);
    check("t1_done_cnt", done_cnt - dc, 1);

    // Device select
    pulse(5'd18, 12'h001, 0, t0);
    wait_frame(400);
    check("t2_word", {8'd0, f_word}, 32'h320010);
    check("t2_dev", {31'd0, f_dev}, 1);
    check("t2_glitch", {31'd0, f_glitch}, 0);
    check("t2_falls", f_falls, 24);
    wait_idle(100);

    // Back-to-back, one pending
    pulse(5'd0, 12'h111, 0, t0);
    pulse(5'd1, 12'h222, t0 + 50, t1);
    wait_frame(400);
    check("b2b_a_word1", {8'd0, f_word}, 32'h301110);
    wait_frame(400);
    check("b2b_a_word2", {8'd0, f_word}, 32'h312220);
    check("b2b_a_start2", f_start, t0 + 205);
    check("b2b_a_drop", {24'd0, m_drop}, 0);
    wait_idle(100);
    check("b2b_a_idle", last_idle, t0 + 409);

    // Back-to-back, pending overwritten once
    pulse(5'd0, 12'h111, 0, t0);
    pulse(5'd1, 12'h222, t0 + 50, t1);
    pulse(5'd2, 12'h333, t0 + 60, t2);
    wait_frame(400);
    check("b2b_b_word1", {8'd0, f_word}, 32'h301110);
    wait_frame(400);
    check("b2b_b_word2", {8'd0, f_word}, 32'h323330);
    check("b2b_b_start2", f_start, t0 + 205);
    check("b2b_b_drop", {24'd0, m_drop}, 1);
    wait_idle(500);

    // Saturation: trig held for 300 cycles
    @(negedge clk);
    trig = 1'b1;
    ch   = 5'd7;
    din  = 12'h777;
    repeat (300) @(negedge clk);
    trig = 1'b0;
    wait_idle(2000);
    check("sat_drop", {24'd0, m_drop}, 8'hFF);

    // Reset mid-frame
    pulse(5'd4, 12'h456, 0, t0);
    while (ncyc < t0 + 100) @(negedge clk);
    #1;
    check("mid_sync_low", {30'd0, m_sync}, 2'b10);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_sync", {30'd0, m_sync}, 2'b11);
    check("mid_rst_sclk", {31'd0, m_sclk}, 1);
    check("mid_rst_sdi", {31'd0, m_sdi}, 0);
    check("mid_rst_busy", {31'd0, m_busy}, 0);
    check("mid_rst_done", {31'd0, m_done}, 0);
    check("mid_rst_drop", {24'd0, m_drop}, 0);
    dc = done_cnt;
    fc = frame_cnt;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("mid_no_done", done_cnt - dc, 0);
    check("mid_no_frame", frame_cnt - fc, 0);
    pulse(5'd5, 12'h5A5, 0, t0);
    wait_frame(400);
    check("post_rst_word", {8'd0, f_word}, 32'h355A50);
    check("post_rst_low", f_low, 196);
    check("post_rst_falls", f_falls, 24);
    wait_idle(100);
    check("post_rst_done_cnt", done_cnt - dc, 1);

    // Minimum divider on the second instance
    sel = 1'b1;
    dc  = done_cnt;
    pulse(5'd31, 12'hFFF, 0, t0);
    wait_frame(400);
    check("div2_word", {8'd0, f_word}, 32'h3FFFF0);
    check("div2_dev", {31'd0, f_dev}, 1);
    check("div2_glitch", {31'd0, f_glitch}, 0);
    check("div2_low", f_low, 98);
    check("div2_falls", f_falls, 24);
    wait_idle(100);
    check("div2_done_cnt", done_cnt - dc, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
